dmem_unit: RTL and testbench
============================

DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning byte-address width; depth = 2^(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 1, meaning load response delay in cycles after accept; legal 1..4.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 half, 10 word; 11 treated as error.
REQ-009 SHALL have port req_unsigned  input  1  loads zero-extend when 1, sign-extend when 0.
REQ-010 SHALL have port req_addr  input  32  byte address.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned, out of range, or had illegal size; valid with rsp_valid.
REQ-015 SHALL have port busy  output  1  memory clear in progress.

Function
REQ-016 SHALL implement FSM states CLEAR, IDLE, WAIT, RESP.
REQ-017 CLEAR SHALL write zero to one word per cycle, index 0 upward, then go to IDLE after word 2^(ADDR_W-2)-1; busy=1 and req_ready=0 throughout.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge with req_valid && req_ready.
REQ-019 At most one request SHALL be outstanding; req_ready=0 from accept until the cycle after rsp_valid.
REQ-020 Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]!=0; any addr[31:ADDR_W] nonzero.
REQ-021 Erroneous request SHALL not modify memory; it gives rsp_valid=1, rsp_err=1, rsp_rdata=0 exactly 1 cycle after accept.
REQ-022 Legal store SHALL write at the accept edge, byte lanes only: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all lanes; other lanes unchanged.
REQ-023 Legal store SHALL give rsp_valid=1, rsp_err=0, rsp_rdata=0 exactly 1 cycle after accept.
REQ-024 Legal load SHALL give rsp_valid=1 exactly LATENCY cycles after accept, via WAIT with a down-counter when LATENCY>1.
REQ-025 Load data SHALL be the word content at the response cycle, shifted to the selected lane, and sign- or zero-extended per req_unsigned and size latched at accept.
REQ-026 Latched request fields SHALL be held internally; later changes on req_* inputs while not ready SHALL have no effect.
REQ-027 rsp_valid SHALL be high exactly one cycle per accepted request; no back-pressure on the response side.
REQ-028 Requests presented while busy=1 SHALL be ignored and never responded to.

Reset
REQ-029 While reset=1 at an edge: state -> CLEAR at word 0, any outstanding request is dropped with no response, and all outputs are 0 except busy=1 from the next cycle.
REQ-030 Reset asserted mid-CLEAR SHALL restart the clear from word 0.
REQ-031 Memory content SHALL be all-zero when busy first falls.

Verification
REQ-032 Reset 1 cycle, ADDR_W=12 -> busy=1 for exactly 1024 cycles, then req_ready=1; word load at 0x3FC returns 0x00000000.
REQ-033 Word store 0x8899AABB at 0x10, byte store 0x5A at 0x12, then signed byte load at 0x12 -> 0x0000005A; word load at 0x10 -> 0x885AAABB.
REQ-034 Store half 0x8001 at 0x22; load half signed at 0x22 -> 0xFFFF8001; unsigned -> 0x00008001; LATENCY=3 -> each rsp_valid exactly 3 cycles after accept, req_ready=0 in between.
REQ-035 Word store at 0x06 or load at 0x1000 (ADDR_W=12) -> rsp_err=1, rsp_rdata=0 one cycle later; the following load of 0x04 shows unchanged data.
REQ-036 Reset asserted during WAIT of an outstanding load -> no rsp_valid, busy=1 next cycle, full clear re-runs, and memory reads 0 afterward.
REQ-037 req_valid held high continuously with alternating stores and loads -> accept only in IDLE, one response per accept, no lost or duplicated responses.

Source files
------------

// File: rtl/dmem_unit.sv
// Byte-addressable data memory with single outstanding request, configurable
// load latency, sub-word access with sign/zero extension, and self-clear after reset.
module dmem_unit #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0]   lat_idx_q, lat_idx_d;
    logic [1:0]         lat_off_q, lat_off_d;
    logic [1:0]         lat_size_q, lat_size_d;
    logic               lat_uns_q, lat_uns_d;
    logic               lat_we_q, lat_we_d;
    logic               lat_err_q, lat_err_d;

    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;

    logic [31:0]        mem_q [DEPTH];
    logic               mem_we;
    logic [IDX_W-1:0]   mem_widx;
    logic [31:0]        mem_wdata;
    logic [3:0]         mem_be;

    logic               req_err;
    logic [31:0]        st_data;
    logic [3:0]         st_be;
    logic [31:0]        rd_word;
    logic [31:0]        rd_shift;
    logic [31:0]        ld_data;

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // Request legality and store lane steering
    always_comb begin
        req_err = (req_size == 2'b11)
               || ((req_size == 2'b01) && req_addr[0])
               || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
               || ((req_addr >> ADDR_W) != 32'd0);
        st_data = req_wdata;
        st_be   = 4'b1111;
        case (req_size)
            2'b00: begin
                st_data = {4{req_wdata[7:0]}};
                st_be   = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_data = {2{req_wdata[15:0]}};
                st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Next-state, request latching and memory write control
    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        cnt_d      = cnt_q;
        lat_idx_d  = lat_idx_q;
        lat_off_d  = lat_off_q;
        lat_size_d = lat_size_q;
        lat_uns_d  = lat_uns_q;
        lat_we_d   = lat_we_q;
        lat_err_d  = lat_err_q;
        mem_we     = 1'b0;
        mem_widx   = clr_idx_q;
        mem_wdata  = '0;
        mem_be     = 4'b0000;

        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_be = 4'b1111;
                if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    lat_idx_d  = req_addr[ADDR_W-1:2];
                    lat_off_d  = req_addr[1:0];
                    lat_size_d = req_size;
                    lat_uns_d  = req_unsigned;
                    lat_we_d   = req_we;
                    lat_err_d  = req_err;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req_we) begin
                        mem_we    = 1'b1;
                        mem_widx  = req_addr[ADDR_W-1:2];
                        mem_wdata = st_data;
                        mem_be    = st_be;
                        state_d   = ST_RESP;
                    end else if (LATENCY <= 1) begin
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 2);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        if (reset) begin
            mem_we = 1'b0;
        end
    end

    // Response formation from the latched request; memory is stable while a load is pending
    always_comb begin
        rd_word  = mem_q[lat_idx_d];
        rd_shift = rd_word >> {lat_off_d, 3'b000};
        case (lat_size_d)
            2'b00:   ld_data = lat_uns_d ? {24'd0, rd_shift[7:0]}
                                         : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   ld_data = lat_uns_d ? {16'd0, rd_shift[15:0]}
                                         : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase
        rsp_valid_d = (state_d == ST_RESP);
        rsp_err_d   = rsp_valid_d && lat_err_d;
        rsp_rdata_d = (rsp_valid_d && !lat_err_d && !lat_we_d) ? ld_data : 32'd0;
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            cnt_q       <= '0;
            lat_idx_q   <= '0;
            lat_off_q   <= '0;
            lat_size_q  <= '0;
            lat_uns_q   <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_err_q   <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            cnt_q       <= cnt_d;
            lat_idx_q   <= lat_idx_d;
            lat_off_q   <= lat_off_d;
            lat_size_q  <= lat_size_d;
            lat_uns_q   <= lat_uns_d;
            lat_we_q    <= lat_we_d;
            lat_err_q   <= lat_err_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Byte-lane write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Directed bench for dmem_unit (ADDR_W=12, LATENCY=3): vector table plus
// hand sequences for clear timing, reset during a pending load, and streaming.
module tb_dmem_unit;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned LATENCY = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_unit #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    typedef struct packed {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic err, input logic [31:0] rd);
        vec_t v;
        v = '{we, sz, uns, a, wd, err, rd};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Called on the negedge right after a reset edge; optionally pokes a store while busy
    task automatic wait_clear(input string nm, input logic poke);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        chk({nm, "_start"}, {29'd0, busy, req_ready, rsp_valid}, 32'b100);
        while (busy && n < 3000) begin
            if (rsp_valid || req_ready) bad++;
            req_valid    = poke && (n < 100);
            req_we       = 1'b1;
            req_size     = 2'b10;
            req_unsigned = 1'b0;
            req_addr     = 32'h3FC;
            req_wdata    = 32'hFFFF_FFFF;
            n++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk({nm, "_busy_cycles"}, 32'(n), 32'd1024);
        chk({nm, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        chk({nm, "_quiet"}, 32'(bad), 32'd0);
    endtask

    // One full transaction; garbage is driven on req_* while the unit is not ready
    task automatic do_req(input string nm, input vec_t v);
        int n;
        int bad;
        int exp_lat;
        exp_lat = (v.err || v.we) ? 1 : int'(LATENCY);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({nm, "_ready_timeout"}, 32'(req_ready), 32'd1);
            return;
        end
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.sz;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wd;
        @(negedge clk);
        req_we       = ~v.we;
        req_size     = 2'b10;
        req_unsigned = ~v.uns;
        req_addr     = 32'h14;
        req_wdata    = 32'hDEAD_BEEF;
        n   = 1;
        bad = 0;
        while (!rsp_valid && n < 20) begin
            if (req_ready) bad++;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
        chk({nm, "_err"}, {31'd0, rsp_err}, {31'd0, v.err});
        chk({nm, "_rdata"}, rsp_rdata, v.rd);
        chk({nm, "_ready_hold"}, 32'(bad + int'(req_ready)), 32'd0);
        @(negedge clk);
        chk({nm, "_after"}, {30'd0, rsp_valid, req_ready}, 32'b01);
    endtask

    initial begin
        vecs[0]  = mk(0, 2'b10, 0, 32'h3FC,  32'h0,         0, 32'h0000_0000);
        vecs[1]  = mk(1, 2'b10, 0, 32'h010,  32'h8899_AABB, 0, 32'h0);
        vecs[2]  = mk(1, 2'b00, 0, 32'h012,  32'hFFFF_FF5A, 0, 32'h0);
        vecs[3]  = mk(0, 2'b00, 0, 32'h012,  32'h0,         0, 32'h0000_005A);
        vecs[4]  = mk(0, 2'b10, 0, 32'h010,  32'h0,         0, 32'h885A_AABB);
        vecs[5]  = mk(0, 2'b00, 0, 32'h013,  32'h0,         0, 32'hFFFF_FF88);
        vecs[6]  = mk(0, 2'b00, 1, 32'h013,  32'h0,         0, 32'h0000_0088);
        vecs[7]  = mk(1, 2'b01, 0, 32'h022,  32'h1234_8001, 0, 32'h0);
        vecs[8]  = mk(0, 2'b01, 0, 32'h022,  32'h0,         0, 32'hFFFF_8001);
        vecs[9]  = mk(0, 2'b01, 1, 32'h022,  32'h0,         0, 32'h0000_8001);
        vecs[10] = mk(0, 2'b10, 0, 32'h020,  32'h0,         0, 32'h8001_0000);
        vecs[11] = mk(1, 2'b10, 0, 32'h004,  32'hCAFE_F00D, 0, 32'h0);
        vecs[12] = mk(1, 2'b10, 0, 32'h006,  32'h1111_1111, 1, 32'h0);
        vecs[13] = mk(0, 2'b10, 0, 32'h1000, 32'h0,         1, 32'h0);
        vecs[14] = mk(0, 2'b01, 0, 32'h021,  32'h0,         1, 32'h0);
        vecs[15] = mk(1, 2'b11, 0, 32'h004,  32'h0,         1, 32'h0);
        vecs[16] = mk(1, 2'b00, 0, 32'h1004, 32'h0000_0077, 1, 32'h0);
        vecs[17] = mk(0, 2'b10, 0, 32'h004,  32'h0,         0, 32'hCAFE_F00D);
        vecs[18] = mk(1, 2'b00, 0, 32'h005,  32'h0000_0000, 0, 32'h0);
        vecs[19] = mk(0, 2'b10, 0, 32'h004,  32'h0,         0, 32'hCAFE_000D);
        vecs[20] = mk(0, 2'b01, 1, 32'h010,  32'h0,         0, 32'h0000_AABB);
        vecs[21] = mk(0, 2'b01, 0, 32'h010,  32'h0,         0, 32'hFFFF_AABB);
        vecs[22] = mk(0, 2'b01, 1, 32'h012,  32'h0,         0, 32'h0000_885A);
        vecs[23] = mk(1, 2'b01, 0, 32'h000,  32'hFFFF_7FFF, 0, 32'h0);
        vecs[24] = mk(0, 2'b01, 0, 32'h000,  32'h0,         0, 32'h0000_7FFF);
        vecs[25] = mk(0, 2'b10, 0, 32'h000,  32'h0,         0, 32'h0000_7FFF);
        vecs[26] = mk(0, 2'b00, 0, 32'h001,  32'h0,         0, 32'h0000_007F);
        vecs[27] = mk(0, 2'b00, 0, 32'h000,  32'h0,         0, 32'hFFFF_FFFF);

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_clear("clear0", 1'b1);

        for (int i = 0; i < NVEC; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while a load waits: no response, full clear, memory zero afterwards
        do_req("pre_rst_st", mk(1, 2'b10, 0, 32'h010, 32'h1234_5678, 0, 32'h0));
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 32'h010;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_wait_norsp", {31'd0, rsp_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_clear("clear1", 1'b0);
        do_req("post_rst_ld10", mk(0, 2'b10, 0, 32'h010, 32'h0, 0, 32'h0));
        do_req("post_rst_ld3fc", mk(0, 2'b10, 0, 32'h3FC, 32'h0, 0, 32'h0));

        // Back-to-back stream with req_valid held high
        begin
            logic [31:0] expq [$];
            logic [31:0] op_wd [12];
            int acc;
            int rsp;
            int cyc;
            int overlap;
            for (int k = 0; k < 12; k++) begin
                op_wd[k] = 32'hA500_0000 + 32'((k / 2) * 32'h0102_0304);
            end
            acc = 0; rsp = 0; cyc = 0; overlap = 0;
            req_valid = 1'b1;
            while ((acc < 12 || expq.size() > 0) && cyc < 300) begin
                if (acc < 12) begin
                    req_we       = (acc % 2) == 0;
                    req_size     = 2'b10;
                    req_unsigned = 1'b0;
                    req_addr     = 32'h80 + 32'(4 * (acc / 2));
                    req_wdata    = op_wd[acc];
                end else begin
                    req_valid = 1'b0;
                end
                if (rsp_valid) begin
                    rsp++;
                    if (expq.size() == 0) begin
                        chk("stream_spurious", 32'(rsp), 32'(acc));
                    end else begin
                        chk($sformatf("stream_rsp%0d", rsp), rsp_rdata, expq.pop_front());
                    end
                end
                if (req_ready && expq.size() != 0) overlap++;
                if (req_ready && req_valid) begin
                    expq.push_back(((acc % 2) == 0) ? 32'h0 : op_wd[acc]);
                    acc++;
                end
                @(negedge clk);
                cyc++;
            end
            req_valid = 1'b0;
            chk("stream_accepts", 32'(acc), 32'd12);
            chk("stream_rsps", 32'(rsp), 32'd12);
            chk("stream_overlap", 32'(overlap), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
